// File: rtl/seq_scan_ctrl_if.sv
// Bus bundle for seq_scan_ctrl: config port, word input handshake and serial/match outputs.
// master = word/config source, slave = the scan controller.
interface seq_scan_ctrl_if #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) ();

    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               s_valid;
    logic [WORD_W-1:0]  s_data;
    logic               s_ready;
    logic               bit_out;
    logic               bit_valid;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, s_valid, s_data,
        input  s_ready, bit_out, bit_valid, match, match_count, busy, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, s_valid, s_data,
        output s_ready, bit_out, bit_valid, match, match_count, busy, cfg_err
    );

endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan controller: accepts words over valid/ready, shifts them MSB-first one bit
// per clock through an overlapping pattern matcher and counts matches (saturating).
// Optional feature: define SEQ_SCAN_CLR_EN to add a synchronous clr input that clears history,
// bits_seen and match_count and suppresses a coincident match.
module seq_scan_ctrl #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
`ifdef SEQ_SCAN_CLR_EN
    input  logic                clr,
`endif
    seq_scan_ctrl_if.slave      bus
);

    localparam int unsigned IdxW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_W - 1);
    localparam logic [3:0]      PatMaxL = 4'(PAT_MAX);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e state_q, state_d;

    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [IdxW-1:0]    bit_idx_q, bit_idx_d;
    logic [PAT_MAX-1:0] history_q, history_d;
    logic [3:0]         bits_seen_q, bits_seen_d;
    logic [PAT_MAX-1:0] pattern_q, pattern_d;
    logic [3:0]         len_q, len_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [PAT_MAX-1:0] len_mask;
    logic               hit;
    logic               clr_req;

`ifdef SEQ_SCAN_CLR_EN
    assign clr_req = clr;
`else
    assign clr_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one IDLE accept cycle followed by WORD_W shift cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.s_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bit_idx_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; bit_out is the MSB because the shift register moves left each bit
    always_comb begin
        bus.s_ready   = (state_q == StIdle);
        bus.busy      = (state_q == StShift);
        bus.bit_valid = (state_q == StShift);
        bus.bit_out   = (state_q == StShift) && shreg_q[WORD_W-1];
    end

    // Registered pulses and counter
    always_comb begin
        bus.match       = match_q;
        bus.match_count = match_count_q;
        bus.cfg_err     = cfg_err_q;
    end

    // Low len bits of the pattern participate in the compare
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    // Datapath next-state: config load, word capture, bit shift, match detect and count
    always_comb begin
        shreg_d       = shreg_q;
        bit_idx_d     = bit_idx_q;
        history_d     = history_q;
        bits_seen_d   = bits_seen_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        match_d       = 1'b0;
        match_count_d = match_count_q;
        cfg_err_d     = 1'b0;
        hit           = 1'b0;

        // Config is evaluated before the word capture so a coincident word uses the new setup
        if (bus.cfg_we) begin
            if ((state_q == StIdle) && (bus.cfg_len <= PatMaxL)) begin
                pattern_d     = bus.cfg_pattern;
                len_d         = bus.cfg_len;
                history_d     = '0;
                bits_seen_d   = '0;
                match_count_d = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (state_q == StIdle) begin
            if (bus.s_valid) begin
                shreg_d   = bus.s_data;
                bit_idx_d = '0;
            end
        end else begin
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_idx_d = bit_idx_q + 1'b1;
            history_d = {history_q[PAT_MAX-2:0], shreg_q[WORD_W-1]};
            if (bits_seen_q < PatMaxL) begin
                bits_seen_d = bits_seen_q + 4'd1;
            end
            hit = (len_q != 4'd0) && (bits_seen_d >= len_q) &&
                  (((history_d ^ pattern_q) & len_mask) == '0);
        end

        // clr overrides both the shift update and any match completed this cycle
        if (clr_req) begin
            history_d     = '0;
            bits_seen_d   = '0;
            match_count_d = '0;
            hit           = 1'b0;
        end

        if (hit) begin
            match_d = 1'b1;
            if (match_count_q != {CNT_W{1'b1}}) begin
                match_count_d = match_count_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q       <= '0;
            bit_idx_q     <= '0;
            history_q     <= '0;
            bits_seen_q   <= '0;
            pattern_q     <= '0;
            len_q         <= '0;
            match_q       <= 1'b0;
            match_count_q <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            bit_idx_q     <= bit_idx_d;
            history_q     <= history_d;
            bits_seen_q   <= bits_seen_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            match_q       <= match_d;
            match_count_q <= match_count_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: a bit-level reference model pushes expected serial
// bits and per-bit match/count results; a negedge monitor pops and compares them.
module tb_seq_scan_ctrl;

    logic clk;
    logic reset;
`ifdef SEQ_SCAN_CLR_EN
    logic clr;
`endif

    seq_scan_ctrl_if #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) bus ();

    seq_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SEQ_SCAN_CLR_EN
        .clr   (clr),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [7:0] m_hist;
    int       m_seen;
    bit [7:0] m_pat;
    int       m_len;
    int       m_cnt;

    bit exp_bits[$];
    bit exp_match[$];
    int exp_cnt[$];
    bit pend;

    function automatic void model_reset();
        m_hist = '0;
        m_seen = 0;
        m_pat  = '0;
        m_len  = 0;
        m_cnt  = 0;
    endfunction

    function automatic void model_bit(input bit b, input bit c);
        bit hit;
        exp_bits.push_back(b);
        m_hist = {m_hist[6:0], b};
        if (m_seen < 8) m_seen++;
        hit = 1'b0;
        if (m_len != 0 && m_seen >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                if (m_hist[i] != m_pat[i]) hit = 1'b0;
            end
        end
        if (c) begin
            m_hist = '0;
            m_seen = 0;
            m_cnt  = 0;
            hit    = 1'b0;
        end
        if (hit && m_cnt < 255) m_cnt++;
        exp_match.push_back(hit);
        exp_cnt.push_back(m_cnt);
    endfunction

    function automatic void model_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) model_bit(w[i], 1'b0);
    endfunction

    // Scoreboard monitor
    bit mon_em;
    bit mon_eb;
    int mon_ec;
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (exp_match.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_match_underflow: match=%0b with no expectation", bus.match);
                end else begin
                    mon_em = exp_match.pop_front();
                    mon_ec = exp_cnt.pop_front();
                    total++;
                    if (bus.match !== mon_em) begin
                        bad++;
                        $display("FAIL sb_match: got %0b want %0b", bus.match, mon_em);
                    end
                    total++;
                    if (bus.match_count !== 8'(mon_ec)) begin
                        bad++;
                        $display("FAIL sb_count: got %0d want %0d", bus.match_count, mon_ec);
                    end
                end
            end else begin
                total++;
                if (bus.match !== 1'b0) begin
                    bad++;
                    $display("FAIL spurious_match: got %0b want 0", bus.match);
                end
            end
            if (bus.bit_valid) begin
                if (exp_bits.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_bit_underflow: bit_valid with no expected bit");
                end else begin
                    mon_eb = exp_bits.pop_front();
                    total++;
                    if (bus.bit_out !== mon_eb) begin
                        bad++;
                        $display("FAIL sb_bit: got %0b want %0b", bus.bit_out, mon_eb);
                    end
                end
            end
            pend = bus.bit_valid;
        end
    end

    task automatic send_word_raw(input logic [7:0] w);
        int n = 0;
        while (!bus.s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.s_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: s_ready=%0b want 1", bus.s_ready);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        model_word(w);
        send_word_raw(w);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus.s_ready && exp_bits.size() == 0 && exp_match.size() == 0 && !pend) break;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL drain_timeout: %0d bits %0d matches pending, want 0",
                     exp_bits.size(), exp_match.size());
        end
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit in_shift);
        bit exp_err;
        exp_err = in_shift || (len > 4'd8);
        if (!exp_err) begin
            m_pat  = pat;
            m_len  = int'(len);
            m_hist = '0;
            m_seen = 0;
            m_cnt  = 0;
        end
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        total++;
        if (bus.cfg_err !== exp_err) begin
            bad++;
            $display("FAIL cfg_err: got %0b want %0b", bus.cfg_err, exp_err);
        end
        @(posedge clk); #1;
        total++;
        if (bus.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_pulse: got %0b want 0", bus.cfg_err);
        end
    endtask

    task automatic check_count(input string name);
        total++;
        if (bus.match_count !== 8'(m_cnt)) begin
            bad++;
            $display("FAIL %s: match_count got %0d want %0d", name, bus.match_count, m_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++;
        if ({bus.s_ready, bus.busy, bus.bit_valid, bus.bit_out, bus.match, bus.cfg_err} !== 6'b100000
            || bus.match_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs: rdy/busy/bv/bo/m/err=%b cnt=%0d want 100000 cnt=0",
                     {bus.s_ready, bus.busy, bus.bit_valid, bus.bit_out, bus.match, bus.cfg_err},
                     bus.match_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        total++;
        if (bus.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %0b want 1", bus.s_ready);
        end
    endtask

    task automatic test_overlap();
        int n;
        do_cfg(8'b0000_1101, 4'd4, 1'b0);
        send_word(8'b1101_1011);
        n = 1;
        while (!bus.s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL throughput: s_ready back after %0d cycles want 9", n);
        end
        wait_drain();
        total++;
        if (bus.match_count !== 8'd2) begin
            bad++;
            $display("FAIL overlap_count: got %0d want 2", bus.match_count);
        end
    endtask

    task automatic test_back_to_back();
        do_cfg(8'b0000_1101, 4'd4, 1'b0);
        send_word(8'h03);
        send_word(8'h40);
        wait_drain();
        total++;
        if (bus.match_count !== 8'd1) begin
            bad++;
            $display("FAIL boundary_count: got %0d want 1", bus.match_count);
        end
    endtask

    task automatic test_saturate();
        do_cfg(8'h01, 4'd1, 1'b0);
        for (int i = 0; i < 33; i++) send_word(8'hFF);
        wait_drain();
        total++;
        if (bus.match_count !== 8'd255) begin
            bad++;
            $display("FAIL saturate_count: got %0d want 255", bus.match_count);
        end
    endtask

    task automatic test_cfg_err();
        do_cfg(8'b0000_1101, 4'd4, 1'b0);
        send_word(8'b1101_1011);
        do_cfg(8'hAA, 4'd2, 1'b1);
        wait_drain();
        check_count("cfg_busy_count");
        do_cfg(8'h00, 4'd9, 1'b0);
        check_count("cfg_len9_count");
        send_word(8'b1101_1011);
        wait_drain();
        check_count("cfg_err_keep");
    endtask

    task automatic test_cfg_with_word();
        m_pat  = 8'b0000_0011;
        m_len  = 3;
        m_hist = '0;
        m_seen = 0;
        m_cnt  = 0;
        model_word(8'b0110_1100);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = 8'b0000_0011;
        bus.cfg_len     = 4'd3;
        bus.s_valid     = 1'b1;
        bus.s_data      = 8'b0110_1100;
        @(posedge clk); #1;
        bus.cfg_we  = 1'b0;
        bus.s_valid = 1'b0;
        total++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL cfg_word_accept: err=%0b busy=%0b want 0 1", bus.cfg_err, bus.busy);
        end
        wait_drain();
        total++;
        if (bus.match_count !== 8'd2) begin
            bad++;
            $display("FAIL cfg_word_count: got %0d want 2", bus.match_count);
        end
    endtask

    task automatic test_reset_mid();
        do_cfg(8'b0000_1101, 4'd4, 1'b0);
        send_word(8'b1101_1011);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_bits.delete();
        exp_match.delete();
        exp_cnt.delete();
        model_reset();
        #1;
        total++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 ||
            bus.match_count !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: rdy=%0b busy=%0b bv=%0b cnt=%0d want 1 0 0 0",
                     bus.s_ready, bus.busy, bus.bit_valid, bus.match_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%0b busy=%0b want 1 0", bus.s_ready, bus.busy);
        end
        send_word(8'b1101_1011);
        wait_drain();
        total++;
        if (bus.match_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_len0: got %0d want 0", bus.match_count);
        end
    endtask

`ifdef SEQ_SCAN_CLR_EN
    task automatic test_clr();
        do_cfg(8'b0000_1101, 4'd4, 1'b0);
        for (int i = 7; i >= 0; i--) model_bit(1'(8'b1101_1011 >> i), (i == 4));
        send_word_raw(8'b1101_1011);
        repeat (3) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_drain();
        total++;
        if (bus.match_count !== 8'd0) begin
            bad++;
            $display("FAIL clr_count: got %0d want 0", bus.match_count);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        pend            = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
`ifdef SEQ_SCAN_CLR_EN
        clr = 1'b0;
`endif
        model_reset();
        test_reset();
        test_overlap();
        test_back_to_back();
        test_saturate();
        test_cfg_err();
        test_cfg_with_word();
        test_reset_mid();
`ifdef SEQ_SCAN_CLR_EN
        test_clr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
